// File: rtl/dac_load_arbiter.sv
// Two-requester arbiter feeding the single DAC load word; one sample is committed
// per DAC frame boundary (rising sync), round-robin between the two holding slots.
module dac_load_arbiter #(
    parameter int DATA_W = 16,
    parameter int UCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync,
    input  logic              valid0,
    input  logic [DATA_W-1:0] data0,
    output logic              ready0,
    input  logic              valid1,
    input  logic [DATA_W-1:0] data1,
    output logic              ready1,
    output logic [DATA_W-1:0] load_out,
    output logic [1:0]        grant,
    output logic [UCNT_W-1:0] underrun_cnt
);

    // state     | meaning
    // IDLE      | arbitration disabled, no commits
    // WAIT_LOW  | enabled, waiting for sync to fall (frame start)
    // WAIT_HIGH | frame in flight, sync rising is a commit boundary
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_HIGH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              full0;
    logic              full1;
    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;
    logic              last_grant;

    logic boundary;
    logic win0;
    logic win1;
    logic cap0;
    logic cap1;
    logic starve;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en) state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!en)        state_next = IDLE;
                else if (!sync) state_next = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!en)       state_next = IDLE;
                else if (sync) state_next = WAIT_LOW;
            end
            default: state_next = IDLE;
        endcase
    end

    // last_grant=1 means requester 1 won last, so requester 0 takes the next tie
    always_comb begin
        boundary = (state == WAIT_HIGH) && en && sync;
        win0     = boundary && full0 && (!full1 || last_grant);
        win1     = boundary && full1 && (!full0 || !last_grant);
        starve   = boundary && !full0 && !full1;
        ready0   = !full0 && !reset;
        ready1   = !full1 && !reset;
        cap0     = valid0 && ready0;
        cap1     = valid1 && ready1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full0 <= 1'b0;
            full1 <= 1'b0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (cap0) begin
                slot0 <= data0;
                full0 <= 1'b1;
            end else if (win0) begin
                full0 <= 1'b0;
            end
            if (cap1) begin
                slot1 <= data1;
                full1 <= 1'b1;
            end else if (win1) begin
                full1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_out     <= '0;
            grant        <= 2'b00;
            last_grant   <= 1'b1;
            underrun_cnt <= '0;
        end else begin
            grant <= {win1, win0};
            if (win0) begin
                load_out   <= slot0;
                last_grant <= 1'b0;
            end else if (win1) begin
                load_out   <= slot1;
                last_grant <= 1'b1;
            end
            if (starve && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + UCNT_W'(1);
            end
        end
    end

endmodule

// File: doc/dac_load_arbiter.md
Name: dac_load_arbiter

Overview:
- Shares the single dac_interface between two sample requesters: requester 0 is the MicroBlaze GPO path and requester 1 is a streaming waveform source.
- Each requester has a 1-deep holding slot with a valid/ready handshake.
- At every DAC frame boundary, derived from the dac_interface sync output, one pending sample is committed to the DAC load word, using round-robin priority.
- Sits between mcs_0/stream logic and dac_interface in top_level, in the clk_10M domain.

Parameters:
- DATA_W, 16, width of the sample words and of load_out (must match dac_interface load).
- UCNT_W, 8, width of the saturating underrun counter.

Ports:
- clk  in  1  clk_10M domain clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  arbitration enable; when low, no commits are made.
- sync  in  1  from dac_interface; low while a frame is shifting, high when idle. A rising edge marks frame completion.
- valid0  in  1  requester 0 has a sample.
- data0  in  DATA_W  requester 0 sample.
- ready0  out  1  slot 0 empty, can accept.
- valid1  in  1  requester 1 has a sample.
- data1  in  DATA_W  requester 1 sample.
- ready1  out  1  slot 1 empty, can accept.
- load_out  out  DATA_W  word driven to dac_interface load.
- grant  out  2  one-hot, 1-cycle pulse identifying the source committed this cycle.
- underrun_cnt  out  UCNT_W  saturating count of frame boundaries with no pending sample.

Behaviour:
- Reset (synchronous, active-high): load_out=0, slots empty, grant=00, underrun_cnt=0, last_grant=1 (requester 0 wins the first tie), FSM=IDLE. ready0/ready1 are forced 0 while reset=1 and go to 1 the cycle after reset drops. Reset mid-frame discards both slots and any pending commit.
- Capture: on a cycle with validN && readyN, dataN is registered into slotN and fullN is set. readyN = ~fullN && ~reset. Captures operate regardless of en.
- FSM:
  - IDLE: no commits. If en=1, go to WAIT_LOW.
  - WAIT_LOW: waiting for a frame to start. If en=0, go to IDLE. If sync=0, go to WAIT_HIGH.
  - WAIT_HIGH: frame in flight. If en=0, go to IDLE. If sync=1, that cycle is a boundary: commit, then go to WAIT_LOW.
  - Enabling while sync is already high requires a full low-high cycle before the first commit; a stale idle level never commits.
- Commit on a boundary cycle, with all outputs registered so they are visible the next cycle:
  - Both slots full: the requester that is not last_grant wins.
  - One slot full: that slot wins.
  - Winner: load_out <= slot data, fullN cleared, grant[N]=1 for exactly one cycle, last_grant <= N.
  - Neither slot full: load_out holds its previous value, grant=00, underrun_cnt increments, saturating at all-ones.
- Simultaneous events:
  - A slot emptied on a boundary cycle cannot capture that same cycle (its ready was 0). It shows ready=1 the following cycle.
  - A capture into the other, empty slot on a boundary cycle is not considered until the next boundary.
- en dropped in WAIT_HIGH: the in-flight boundary is abandoned with no commit and no underrun count. Slots keep their contents.
- load_out changes only on commit or reset. Latency from a boundary cycle to the new load_out is 1 cycle.

Test Plan:
- Reset then idle: reset 3 cycles → load_out=0000, grant=00, underrun_cnt=0, ready0=ready1=0 during reset and 1 on the cycle after.
- Single source: en=1, push data0=0x0A5A, then sync 1→0→1 → on the cycle after the rise, load_out=0x0A5A, grant=01 for one cycle, ready0 returns to 1, underrun_cnt=0.
- Round-robin: both slots loaded (0x1111, 0x2222) before each of 4 boundaries, refilled after each grant → grant sequence 01,10,01,10 and load_out sequence 1111,2222,1111,2222.
- Underrun/saturation: en=1, no data, 300 boundaries → load_out unchanged, underrun_cnt=0xFF and held there.
- Enable edge cases:
  - Assert en while sync=1 with slot0 full → no commit until sync falls and rises.
  - Drop en during WAIT_HIGH, then sync rises → no commit, slot0 still full, counter unchanged.
- Reset mid-operation: slots full, sync low, reset pulsed 1 cycle, then sync rises with en=1 → no commit, underrun_cnt=0, FSM restarts from IDLE.
